// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU datapath types and constants used by the
//               instruction memory and the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Instruction address width (4096-word space) and instruction width
    localparam int ADDR_W = 12;
    localparam int INS_W  = 19;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INS_W-1:0]  ins_t;

    // Fetch control state: IDLE until fetching is enabled, RUN while it is
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    // Saturation ceiling of the delivered-instruction counter
    localparam logic [15:0] c_count_max = 16'hFFFF;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/ins_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ins_fetch
// Description : Instruction fetch unit. Owns the PC, addresses an async-read
//               instruction memory, registers the returned word into a
//               valid/ready output stage, handles redirects with flush and
//               counts delivered instructions (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module ins_fetch #(
    parameter int                        ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                        INS_W    = cpu_pkg::INS_W,
    parameter logic [cpu_pkg::ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INS_W-1:0]  mem_ins,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [INS_W-1:0]  ins_data,
    output logic [ADDR_W-1:0] ins_pc,
    output logic [15:0]       fetch_count
);

    import cpu_pkg::*;

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_ins_valid;
    logic [INS_W-1:0]  r_ins_data;
    logic [ADDR_W-1:0] r_ins_pc;
    logic [15:0]       r_fetch_count;

    logic              w_free;
    logic              w_handshake;

    // Output stage can take a new word when empty or being drained this cycle
    assign w_free      = !r_ins_valid || ins_ready;
    assign w_handshake = r_ins_valid && ins_ready;

    // Memory is read combinationally from the current PC
    assign mem_addr    = r_pc;

    assign ins_valid   = r_ins_valid;
    assign ins_data    = r_ins_data;
    assign ins_pc      = r_ins_pc;
    assign fetch_count = r_fetch_count;

    // PC, output stage, state and counter; redirect beats fetch and stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC[ADDR_W-1:0];
            r_ins_valid   <= 1'b0;
            r_ins_data    <= '0;
            r_ins_pc      <= '0;
            r_fetch_count <= '0;
        end else begin
            // State tracks whether fetching is enabled; it does not add latency
            case (r_state)
                IDLE:    if (fetch_en)  r_state <= RUN;
                RUN:     if (!fetch_en) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            // A handshake counts even when a redirect flushes in the same cycle
            if (w_handshake && (r_fetch_count != c_count_max)) begin
                r_fetch_count <= r_fetch_count + 16'd1;
            end

            if (redirect_valid) begin
                // Flush: any held word is discarded, fetching resumes at target
                r_pc        <= redirect_target;
                r_ins_valid <= 1'b0;
            end else if (fetch_en && w_free) begin
                // Capture the word at the current PC and advance (wraps mod 2^ADDR_W)
                r_ins_data  <= mem_ins;
                r_ins_pc    <= r_pc;
                r_ins_valid <= 1'b1;
                r_pc        <= r_pc + 1'b1;
            end else if (w_free) begin
                // Drain without refill; data registers keep their last value
                r_ins_valid <= 1'b0;
            end
            // Otherwise stalled: everything holds
        end
    end

endmodule : ins_fetch
`default_nettype wire

// File: doc/ins_fetch.md
# ins_fetch

Instruction fetch unit for the single-cycle/multicycle CPU datapath. Owns the program counter, drives the 12-bit address of the asynchronous-read instruction memory, and registers the returned 19-bit instruction into an output stage with a valid/ready handshake toward decode. Accepts branch/jump redirects with flush, and keeps a saturating count of delivered instructions.

## Interface

- ADDR_W, 12, instruction address width (4096-word space)
- INS_W, 19, instruction width
- RESET_PC, 0, PC value after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_en  in  1  permits new fetches; 0 pauses fetching without losing state
- mem_addr  out  ADDR_W  address to instruction memory, combinational copy of pc
- mem_ins  in  INS_W  instruction word from memory, valid same cycle as mem_addr
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_target  in  ADDR_W  new PC when redirect_valid
- ins_valid  out  1  ins_data/ins_pc hold a deliverable instruction
- ins_ready  in  1  decode accepts when ins_valid && ins_ready
- ins_data  out  INS_W  fetched instruction
- ins_pc  out  ADDR_W  address ins_data was fetched from
- fetch_count  out  16  number of handshakes completed, saturating

## Operation

- Reset (rst=1 at edge): pc=RESET_PC, ins_valid=0, ins_data=0, ins_pc=0, fetch_count=0, state=IDLE.
- States: IDLE (no fetch since reset or fetch_en low) and RUN. IDLE->RUN when fetch_en=1; RUN->IDLE when fetch_en=0. State only gates fetching; the output stage drains normally in either state.
- Output stage "free" = !ins_valid || ins_ready.
- Fetch (state-independent condition: fetch_en && free && !redirect_valid): ins_data<=mem_ins, ins_pc<=pc, ins_valid<=1, pc<=pc+1.
- PC arithmetic modulo 2^ADDR_W: 4095+1 -> 0, no flag.
- Drain without fetch (free, !fetch_en, !redirect_valid): ins_valid<=0 if a handshake occurred; data regs hold.
- Stall (ins_valid && !ins_ready && !redirect_valid): pc, ins_data, ins_pc, ins_valid all hold.
- Redirect (redirect_valid=1): highest priority over fetch and stall. pc<=redirect_target, ins_valid<=0 (in-flight instruction discarded even if unaccepted). A handshake in the same cycle still counts.
- fetch_count increments on every ins_valid && ins_ready cycle; holds at 16'hFFFF.
- rst overrides everything, including a concurrent redirect or handshake.

## Timing

- mem_addr = pc combinationally; zero-latency memory read assumed in the same cycle.
- Fetch latency: pc presented in cycle N -> ins_valid=1 with ins_pc=pc in N+1.
- Back-to-back: with fetch_en=1 and ins_ready=1, one instruction per cycle, consecutive ins_pc.
- Redirect in cycle N -> ins_valid=0 in N+1 -> target instruction valid in N+2 with ins_pc=redirect_target (one bubble).
- First instruction after rst deasserts and fetch_en=1 in cycle N: ins_valid=1 at N+1 with ins_pc=RESET_PC.
- ins_data/ins_pc stable while ins_valid && !ins_ready (handshake rule: producer never retracts or changes valid data except by redirect or reset).

## Structure

- Shared package cpu_pkg: ADDR_W, INS_W, typedefs addr_t (logic[11:0]) and ins_t (logic[18:0]), fetch state enum {IDLE, RUN}; instruction memory and fetch use the same types.
- Flat module; no sub-module needed. PC register, output register, state register, and counter in one block (~150 lines).

## Test plan

- Reset then fetch_en=1, ins_ready=1, memory loaded with word k = k: ins_pc/ins_data = 0,1,2,3 on consecutive cycles starting one cycle after fetch_en; fetch_count=4 after four handshakes.
- ins_ready=0 for 3 cycles while ins_valid with ins_pc=5: outputs hold pc 5 / data unchanged, mem_addr stays 6, fetch_count unchanged; ready=1 -> pc 6 delivered next cycle.
- redirect_valid=1, target=12'h00A while ins_valid (ins_pc=3, ready=0): next cycle ins_valid=0, following cycle ins_pc=10; instruction at 3 never handshaken.
- redirect to 12'hFFE with continuous ready: ins_pc sequence FFE, FFF, 000, 001.
- rst asserted mid-stream together with redirect_valid=1 target=12'h020: next cycle ins_valid=0, pc=0, fetch_count=0; no fetch from 0x020.
- Preload fetch_count to 16'hFFFE via 65534 handshakes (or force), two more handshakes: count reads FFFF and stays FFFF.
